// File: rtl/t07_fpu_issue_wb.sv
// Issue/writeback sequencer for t07_FPU: accepts one request at a time,
// resolves the rounding mode against fcsr, keeps the FPU inputs stable while
// the unit is busy, and returns the result through a valid/ready port.
module t07_fpu_issue_wb #(
    parameter int unsigned TIMEOUT_W = 6,
    parameter logic [31:0] QNAN      = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [2:0]  req_rm,
    input  logic [4:0]  req_rd,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [31:0] req_c,
    output logic [31:0] fpu_valA,
    output logic [31:0] fpu_valB,
    output logic [31:0] fpu_valC,
    output logic [4:0]  fpu_op,
    output logic [31:0] fpu_fcsr,
    input  logic        fpu_busy,
    input  logic [31:0] fpu_result,
    input  logic [6:0]  fpu_flags,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    input  logic        csr_we,
    input  logic [31:0] csr_wdata,
    output logic [31:0] fcsr,
    output logic        err_timeout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WB
    } state_e;

    localparam logic [4:0] FLAG_NV = 5'b10000;

    state_e                 state_q, state_d;
    logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]            a_q, a_d;
    logic [31:0]            b_q, b_d;
    logic [31:0]            c_q, c_d;
    logic [4:0]             op_q, op_d;
    logic [2:0]             rm_q, rm_d;
    logic [4:0]             rd_q, rd_d;
    logic [31:0]            wb_data_q, wb_data_d;
    logic [2:0]             frm_q, frm_d;
    logic [4:0]             fflags_q, fflags_d;

    logic                   accept;
    logic [2:0]             eff_rm;
    logic [4:0]             flags_set;
    logic                   timeout;

    // FPU flag bits [6:5] and the upper CSR write bits are not stored.
    logic unused_inputs;
    assign unused_inputs = ^{fpu_flags[6:5], csr_wdata[31:8]};

    assign accept = req_valid && (state_q == S_IDLE);
    assign eff_rm = (req_rm == 3'b111) ? frm_q : req_rm;

    // Next-state, datapath capture and fcsr update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        op_d      = op_q;
        rm_d      = rm_q;
        rd_d      = rd_q;
        wb_data_d = wb_data_q;
        frm_d     = frm_q;
        fflags_d  = fflags_q;
        flags_set = '0;
        timeout   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d  = req_a;
                    b_d  = req_b;
                    c_d  = req_c;
                    op_d = req_op;
                    rd_d = req_rd;
                    rm_d = eff_rm;
                    if (eff_rm >= 3'd5) begin
                        wb_data_d = QNAN;
                        flags_set = FLAG_NV;
                        state_d   = S_WB;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!fpu_busy) begin
                    wb_data_d = fpu_result;
                    flags_set = fpu_flags[4:0];
                    state_d   = S_WB;
                end else if (cnt_q == '1) begin
                    wb_data_d = QNAN;
                    flags_set = FLAG_NV;
                    timeout   = 1'b1;
                    state_d   = S_WB;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_W'(1);
                end
            end
            S_WB: begin
                if (wb_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A software write takes priority; the op's flags are dropped.
        if (csr_we) begin
            frm_d    = csr_wdata[7:5];
            fflags_d = csr_wdata[4:0];
        end else begin
            fflags_d = fflags_q | flags_set;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            op_q      <= '0;
            rm_q      <= '0;
            rd_q      <= '0;
            wb_data_q <= '0;
            frm_q     <= '0;
            fflags_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            op_q      <= op_d;
            rm_q      <= rm_d;
            rd_q      <= rd_d;
            wb_data_q <= wb_data_d;
            frm_q     <= frm_d;
            fflags_q  <= fflags_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign wb_valid    = (state_q == S_WB);
    assign wb_rd       = rd_q;
    assign wb_data     = wb_data_q;
    assign fpu_valA    = a_q;
    assign fpu_valB    = b_q;
    assign fpu_valC    = c_q;
    assign fpu_op      = op_q;
    assign fpu_fcsr    = {24'b0, rm_q, fflags_q};
    assign fcsr        = {24'b0, frm_q, fflags_q};
    assign err_timeout = timeout;

endmodule

// File: tb/tb_t07_fpu_issue_wb.sv
// Self-checking bench for t07_fpu_issue_wb: directed vector table, hand-written
// corner sequences, and randomized ops checked against a transaction model.
module tb_t07_fpu_issue_wb;

    logic        clk = 1'b0;
    logic        nrst;
    logic        req_valid, req_ready;
    logic [4:0]  req_op, req_rd;
    logic [2:0]  req_rm;
    logic [31:0] req_a, req_b, req_c;
    logic [31:0] fpu_valA, fpu_valB, fpu_valC, fpu_fcsr;
    logic [4:0]  fpu_op;
    logic        fpu_busy;
    logic [31:0] fpu_result;
    logic [6:0]  fpu_flags;
    logic        wb_valid, wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        csr_we;
    logic [31:0] csr_wdata, fcsr;
    logic        err_timeout;

    int tests = 0;
    int fails = 0;
    logic [7:0] m_fcsr;  // model of fcsr[7:0]

    localparam logic [31:0] QN = 32'h7FC00000;

    t07_fpu_issue_wb #(.TIMEOUT_W(6), .QNAN(32'h7FC00000)) dut (
        .clk(clk), .nrst(nrst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rm(req_rm), .req_rd(req_rd), .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .fpu_valA(fpu_valA), .fpu_valB(fpu_valB), .fpu_valC(fpu_valC),
        .fpu_op(fpu_op), .fpu_fcsr(fpu_fcsr), .fpu_busy(fpu_busy),
        .fpu_result(fpu_result), .fpu_flags(fpu_flags),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .csr_we(csr_we), .csr_wdata(csr_wdata), .fcsr(fcsr), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  csr;
        logic [2:0]  rm;
        int          busy;
        logic [31:0] res;
        logic [6:0]  flg;
        int          hold;
        logic [31:0] exp_data;
        int          exp_lat;
        logic [7:0]  exp_fcsr;
        logic [2:0]  exp_rm;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [7:0] v);
        csr_we    = 1'b1;
        csr_wdata = {$urandom_range(0, 255) == 0 ? 24'h0 : 24'(($urandom)), v};
        tick();
        csr_we = 1'b0;
        m_fcsr = v;
        chk("csr_write", fcsr, {24'h0, v});
    endtask

    // One complete op: accept, stub the FPU for busy_n cycles, then hold the
    // writeback for 'hold' cycles while offering a competing request.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                          input logic [4:0] op, input logic [4:0] rd, input logic [2:0] rm,
                          input int busy_n, input logic [31:0] res, input logic [6:0] flg,
                          input int hold, input logic [31:0] exp_data, input int exp_lat,
                          input logic [7:0] exp_fcsr, input logic [2:0] exp_rm);
        int idx;
        bit got;
        logic [7:0] pre;
        pre = m_fcsr;
        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_a = a; req_b = b; req_c = c;
        req_op = op; req_rd = rd; req_rm = rm;
        fpu_result = res; fpu_flags = flg; fpu_busy = 1'b0;
        tick();
        req_valid = 1'b0;
        got = 1'b0;
        idx = 1;
        while (!got && idx <= exp_lat + 4) begin
            fpu_busy = (idx >= 2 && idx <= 1 + busy_n);
            #1;
            if (idx == 1 && exp_lat > 1)
                chk("issue_fpu_fcsr", fpu_fcsr, {24'h0, exp_rm, pre[4:0]});
            chk("fpu_valA_hold", fpu_valA, a);
            chk("fpu_valB_hold", fpu_valB, b);
            chk("fpu_valC_hold", fpu_valC, c);
            chk("fpu_op_hold", {27'b0, fpu_op}, {27'b0, op});
            if (wb_valid) begin
                got = 1'b1;
            end else begin
                chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
                tick();
                idx++;
            end
        end
        fpu_busy = 1'b0;
        if (!got) begin
            chk("wb_valid_never", 32'd0, 32'd1);
        end else begin
            chk("latency", 32'(idx), 32'(exp_lat));
            chk("wb_data", wb_data, exp_data);
            chk("wb_rd", {27'b0, wb_rd}, {27'b0, rd});
        end
        req_valid = 1'b1; req_a = ~a; req_op = ~op; req_rm = 3'b000;
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_wb_valid", {31'b0, wb_valid}, 32'd1);
            chk("hold_wb_data", wb_data, exp_data);
            chk("hold_wb_rd", {27'b0, wb_rd}, {27'b0, rd});
            chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
        end
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        req_valid = 1'b0;
        chk("post_hs_req_ready", {31'b0, req_ready}, 32'd1);
        chk("post_hs_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("post_hs_valA", fpu_valA, a);
        chk("fcsr_after_op", fcsr, {24'h0, exp_fcsr});
        m_fcsr = exp_fcsr;
    endtask

    initial begin
        nrst = 1'b1; req_valid = 1'b0; req_op = '0; req_rm = '0; req_rd = '0;
        req_a = '0; req_b = '0; req_c = '0; fpu_busy = 1'b0; fpu_result = '0;
        fpu_flags = '0; wb_ready = 1'b0; csr_we = 1'b0; csr_wdata = '0;
        m_fcsr = '0;

        tbl[0] = '{8'h20, 3'b111, 0, 32'hBF980000, 7'h01, 0, 32'hBF980000, 3, 8'h21, 3'b001};
        tbl[1] = '{8'h00, 3'b000, 4, 32'h3F800000, 7'h00, 5, 32'h3F800000, 7, 8'h00, 3'b000};
        tbl[2] = '{8'h00, 3'b101, 0, 32'h12345678, 7'h00, 1, QN,           1, 8'h10, 3'b101};
        tbl[3] = '{8'hE0, 3'b111, 0, 32'h12345678, 7'h00, 0, QN,           1, 8'hF0, 3'b111};
        tbl[4] = '{8'h03, 3'b010, 2, 32'hDEADBEEF, 7'h64, 2, 32'hDEADBEEF, 5, 8'h07, 3'b010};
        tbl[5] = '{8'h80, 3'b111, 1, 32'hAAAA5555, 7'h1F, 0, 32'hAAAA5555, 4, 8'h9F, 3'b100};
        tbl[6] = '{8'h00, 3'b110, 3, 32'h0BADF00D, 7'h08, 3, QN,           1, 8'h10, 3'b110};

        repeat (3) @(posedge clk);
        #1;
        nrst = 1'b0;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_fcsr", fcsr, 32'd0);
        chk("rst_fpu_fcsr", fpu_fcsr, 32'd0);
        chk("rst_err_timeout", {31'b0, err_timeout}, 32'd0);
        tick();

        for (int i = 0; i < 7; i++) begin
            csr_write(tbl[i].csr);
            run_op(32'hC0C80000, 32'h40A20000, 32'(i) * 32'h01010101, 5'(i), 5'(i + 1),
                   tbl[i].rm, tbl[i].busy, tbl[i].res, tbl[i].flg, tbl[i].hold,
                   tbl[i].exp_data, tbl[i].exp_lat, tbl[i].exp_fcsr, tbl[i].exp_rm);
        end

        // CSR write on the capture edge overrides the op's flags.
        csr_write(8'h00);
        req_valid = 1'b1; req_a = 32'h11111111; req_b = 32'h22222222; req_c = 32'h33333333;
        req_op = 5'd3; req_rd = 5'd9; req_rm = 3'b000;
        fpu_result = 32'h44444444; fpu_flags = 7'h04; fpu_busy = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        csr_we = 1'b1; csr_wdata = 32'h00000040;
        tick();
        csr_we = 1'b0;
        chk("coll_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("coll_wb_data", wb_data, 32'h44444444);
        chk("coll_fcsr", fcsr, 32'h40);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        m_fcsr = 8'h40;

        // Timeout with busy stuck high: one pulse at WAIT cycle 64.
        begin
            int pulses, pulse_idx, wb_idx;
            pulses = 0; pulse_idx = 0; wb_idx = 0;
            req_valid = 1'b1; req_a = 32'h5A5A5A5A; req_rm = 3'b001; req_rd = 5'd17;
            fpu_busy = 1'b0;
            tick();
            req_valid = 1'b0;
            for (int idx = 1; idx <= 100 && wb_idx == 0; idx++) begin
                fpu_busy = (idx >= 2);
                #1;
                if (err_timeout) begin
                    pulses++;
                    pulse_idx = idx;
                    chk("to_wb_not_yet", {31'b0, wb_valid}, 32'd0);
                end
                if (wb_valid) wb_idx = idx;
                else tick();
            end
            chk("to_pulse_count", 32'(pulses), 32'd1);
            chk("to_pulse_idx", 32'(pulse_idx), 32'd65);
            chk("to_wb_idx", 32'(wb_idx), 32'd66);
            chk("to_wb_data", wb_data, QN);
            chk("to_fcsr", fcsr, {24'h0, m_fcsr | 8'h10});
            fpu_busy = 1'b0;
            wb_ready = 1'b1;
            tick();
            wb_ready = 1'b0;
            m_fcsr = m_fcsr | 8'h10;
        end

        // Reset in the middle of WAIT aborts everything immediately.
        req_valid = 1'b1; req_a = 32'h77777777; req_op = 5'd5; req_rm = 3'b000;
        tick();
        req_valid = 1'b0;
        fpu_busy = 1'b1;
        repeat (10) tick();
        nrst = 1'b1;
        #1;
        chk("arst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("arst_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("arst_wb_rd", {27'b0, wb_rd}, 32'd0);
        chk("arst_wb_data", wb_data, 32'd0);
        chk("arst_valA", fpu_valA, 32'd0);
        chk("arst_op", {27'b0, fpu_op}, 32'd0);
        chk("arst_fpu_fcsr", fpu_fcsr, 32'd0);
        chk("arst_fcsr", fcsr, 32'd0);
        chk("arst_err_timeout", {31'b0, err_timeout}, 32'd0);
        fpu_busy = 1'b0;
        tick();
        nrst = 1'b0;
        m_fcsr = '0;
        tick();

        // Randomized ops against the transaction-level model.
        for (int n = 0; n < 40; n++) begin
            logic [2:0]  rm, eff;
            logic [31:0] res, exp_d;
            logic [6:0]  flg;
            logic [4:0]  fl;
            int          bsy, lat;
            if ($urandom_range(0, 3) == 0) csr_write(8'($urandom));
            rm  = 3'($urandom);
            res = $urandom;
            flg = 7'($urandom);
            bsy = $urandom_range(0, 8);
            eff = (rm == 3'b111) ? m_fcsr[7:5] : rm;
            if (eff >= 3'd5) begin
                exp_d = QN; lat = 1; fl = 5'b10000;
            end else begin
                exp_d = res; lat = 3 + bsy; fl = flg[4:0];
            end
            run_op($urandom, $urandom, $urandom, 5'($urandom), 5'($urandom), rm,
                   bsy, res, flg, $urandom_range(0, 3), exp_d, lat,
                   {m_fcsr[7:5], m_fcsr[4:0] | fl}, eff);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
